world_editor: RTL and testbench

Places and removes cubes in the world memory on request. It consumes the looked-at cube index and face normal that the world drawer reports at the end of each frame. It owns the second (read/write) port of the dual-port world RAM, whose first port the drawer reads. A place writes a new valid entry adjacent to the targeted face into the first free slot; a remove clears the targeted entry.

---
 rtl/world_editor.sv | 265 ++++++++++++++++++++++++++
 tb/tb_world_editor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/world_editor.sv
// world_editor: places and removes cubes in the world RAM through its
// read/write port, targeting the cube and face the drawer reports.
//
// Request/completion handshake: place_req/remove_req are sampled on a rising
// edge while the editor is idle (IDLE, or the FINISH cycle that pulses done).
// An accepted request raises busy from the next cycle until done; done is a
// single-cycle pulse with busy low, and status/edited_slot change only with
// done. Requests seen while busy are dropped, not queued.
module world_editor #(
  parameter int COORD_WIDTH  = 32,
  parameter int WORLD_SIZE   = 100,
  parameter int WORLD_BITS   = 7,
  parameter int NORMAL_WIDTH = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   place_req,
  input  logic                                   remove_req,
  input  logic [WORLD_BITS-1:0]                  looked_at_cube,
  input  logic [2:0][NORMAL_WIDTH-1:0]           looked_at_normal,
  output logic [WORLD_BITS-1:0]                  mem_addr,
  output logic [3*(COORD_WIDTH/2):0]             mem_wdata,
  output logic                                   mem_we,
  input  logic [3*(COORD_WIDTH/2):0]             mem_rdata,
  output logic                                   busy,
  output logic                                   done,
  output logic [1:0]                             status,
  output logic [WORLD_BITS-1:0]                  edited_slot,
  output logic [2:0]                             fsm_state
);

  localparam int HW = COORD_WIDTH / 2;
  localparam int EW = 3 * HW + 1;
  localparam int CW = $clog2(READ_LATENCY + 1) + 1;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_NO_TARGET = 2'd1;
  localparam logic [1:0] ST_OCCUPIED  = 2'd2;
  localparam logic [1:0] ST_FULL      = 2'd3;

  // Most negative normal code has no opposite face; it contributes nothing.
  localparam logic [NORMAL_WIDTH-1:0] NORM_MIN = {1'b1, {(NORMAL_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REMOVE   = 3'd1,
    S_READ_TGT = 3'd2,
    S_SCAN     = 3'd3,
    S_WRITE    = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [WORLD_BITS-1:0]          tgt_q;
  logic [2:0][NORMAL_WIDTH-1:0]   normal_q;
  logic [2:0][HW-1:0]             new_coord_q;
  logic [CW-1:0]                  cnt_q;
  logic [WORLD_BITS:0]            issue_cnt_q;
  logic [WORLD_BITS-1:0]          addr_hold_q;
  logic [WORLD_BITS-1:0]          apipe_q [READ_LATENCY];
  logic                           vpipe_q [READ_LATENCY];
  logic                           occ_q;
  logic                           free_found_q;
  logic [WORLD_BITS-1:0]          free_slot_q;
  logic [1:0]                     status_q;
  logic [WORLD_BITS-1:0]          edited_q;

  logic                           idle_like;
  logic                           accept;
  logic                           tgt_bad;
  logic                           issuing;
  logic                           rd_valid_bit;
  logic [2:0][HW-1:0]             norm_ext;
  logic [2:0][HW-1:0]             adj_coord;
  logic                           ret_valid;
  logic [WORLD_BITS-1:0]          ret_addr;
  logic                           match;
  logic                           free_hit;
  logic                           scan_last;
  logic                           occ_now;
  logic                           free_found_now;
  logic [WORLD_BITS-1:0]          free_slot_now;
  logic                           fin_load;
  logic [1:0]                     fin_status;
  logic                           edit_load;
  logic [WORLD_BITS-1:0]          edit_slot_d;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign accept    = idle_like && (place_req || remove_req);
  assign tgt_bad   = (looked_at_cube == '1) ||
                     ({1'b0, looked_at_cube} >= (WORLD_BITS+1)'(WORLD_SIZE));
  assign issuing   = (state_q == S_SCAN) &&
                     (issue_cnt_q < (WORLD_BITS+1)'(WORLD_SIZE));

  assign rd_valid_bit = mem_rdata[EW-1];
  assign ret_valid    = vpipe_q[READ_LATENCY-1];
  assign ret_addr     = apipe_q[READ_LATENCY-1];
  assign match        = ret_valid && rd_valid_bit &&
                        (mem_rdata[3*HW-1:0] == new_coord_q);
  assign free_hit     = ret_valid && !rd_valid_bit;
  assign scan_last    = ret_valid && (ret_addr == WORLD_BITS'(WORLD_SIZE - 1));

  assign occ_now        = occ_q | match;
  assign free_found_now = free_found_q | free_hit;
  assign free_slot_now  = (!free_found_q && free_hit) ? ret_addr : free_slot_q;

  // Neighbour coordinate: target coordinate plus sign-extended normal, wrapping.
  always_comb begin
    norm_ext  = '0;
    adj_coord = '0;
    for (int a = 0; a < 3; a++) begin
      if (normal_q[a] == NORM_MIN) begin
        norm_ext[a] = '0;
      end else begin
        norm_ext[a] = {{(HW-NORMAL_WIDTH){normal_q[a][NORMAL_WIDTH-1]}}, normal_q[a]};
      end
      adj_coord[a] = mem_rdata[a*HW +: HW] + norm_ext[a];
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and result reporting for the FINISH cycle.
  always_comb begin
    state_d     = state_q;
    fin_load    = 1'b0;
    fin_status  = ST_OK;
    edit_load   = 1'b0;
    edit_slot_d = tgt_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (accept) begin
          if (tgt_bad) begin
            state_d    = S_FINISH;
            fin_load   = 1'b1;
            fin_status = ST_NO_TARGET;
          end else if (remove_req) begin
            state_d = S_REMOVE;
          end else begin
            state_d = S_READ_TGT;
          end
        end
      end
      S_REMOVE: begin
        state_d     = S_FINISH;
        fin_load    = 1'b1;
        fin_status  = ST_OK;
        edit_load   = 1'b1;
        edit_slot_d = tgt_q;
      end
      S_READ_TGT: begin
        if (cnt_q == CW'(READ_LATENCY)) begin
          if (!rd_valid_bit) begin
            state_d    = S_FINISH;
            fin_load   = 1'b1;
            fin_status = ST_NO_TARGET;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (scan_last) begin
          if (occ_now) begin
            state_d    = S_FINISH;
            fin_load   = 1'b1;
            fin_status = ST_OCCUPIED;
          end else if (!free_found_now) begin
            state_d    = S_FINISH;
            fin_load   = 1'b1;
            fin_status = ST_FULL;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        state_d     = S_FINISH;
        fin_load    = 1'b1;
        fin_status  = ST_OK;
        edit_load   = 1'b1;
        edit_slot_d = free_slot_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port address: target, scan address or free slot; otherwise hold.
  always_comb begin
    mem_addr = addr_hold_q;
    case (state_q)
      S_REMOVE, S_READ_TGT: mem_addr = tgt_q;
      S_SCAN:               if (issuing) mem_addr = issue_cnt_q[WORLD_BITS-1:0];
      S_WRITE:              mem_addr = free_slot_q;
      default:              mem_addr = addr_hold_q;
    endcase
  end

  assign mem_we      = (state_q == S_REMOVE) || (state_q == S_WRITE);
  assign mem_wdata   = (state_q == S_WRITE) ? {1'b1, new_coord_q} : '0;
  assign busy        = (state_q == S_REMOVE) || (state_q == S_READ_TGT) ||
                       (state_q == S_SCAN)   || (state_q == S_WRITE);
  assign done        = (state_q == S_FINISH);
  assign status      = status_q;
  assign edited_slot = edited_q;
  assign fsm_state   = state_q;

  // Datapath: request latch, read-latency counter, scan pipeline and results.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tgt_q        <= '0;
      normal_q     <= '0;
      new_coord_q  <= '0;
      cnt_q        <= '0;
      issue_cnt_q  <= '0;
      addr_hold_q  <= '0;
      occ_q        <= 1'b0;
      free_found_q <= 1'b0;
      free_slot_q  <= '0;
      status_q     <= ST_OK;
      edited_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        apipe_q[i] <= '0;
        vpipe_q[i] <= 1'b0;
      end
    end else begin
      addr_hold_q <= mem_addr;
      apipe_q[0]  <= issue_cnt_q[WORLD_BITS-1:0];
      vpipe_q[0]  <= issuing;
      for (int i = 1; i < READ_LATENCY; i++) begin
        apipe_q[i] <= apipe_q[i-1];
        vpipe_q[i] <= vpipe_q[i-1];
      end
      if (accept) begin
        tgt_q        <= looked_at_cube;
        normal_q     <= looked_at_normal;
        cnt_q        <= '0;
        issue_cnt_q  <= '0;
        occ_q        <= 1'b0;
        free_found_q <= 1'b0;
        free_slot_q  <= '0;
      end
      if (state_q == S_READ_TGT) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(READ_LATENCY)) new_coord_q <= adj_coord;
      end
      if (issuing) issue_cnt_q <= issue_cnt_q + (WORLD_BITS+1)'(1);
      if (state_q == S_SCAN) begin
        occ_q        <= occ_now;
        free_found_q <= free_found_now;
        free_slot_q  <= free_slot_now;
      end
      if (fin_load)  status_q <= fin_status;
      if (edit_load) edited_q <= edit_slot_d;
    end
  end

endmodule

// File: tb/tb_world_editor.sv
// tb_world_editor: table of place/remove operations against a behavioural
// world RAM, plus hand sequences for requests-while-busy and reset mid-scan.
module tb_world_editor;

  localparam int CW = 32;
  localparam int WS = 100;
  localparam int WB = 7;
  localparam int NW = 2;
  localparam int L  = 2;
  localparam int EW = 3 * (CW / 2) + 1;

  localparam int D_IDX   = 1;
  localparam int D_RM    = 2;
  localparam int D_INV   = 2 + L;
  localparam int D_SCAN  = 2 + 2 * L + WS;
  localparam int D_OK    = D_SCAN + 1;
  localparam int TIMEOUT = 300;
  localparam int NV      = 14;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic                   place_req = 1'b0;
  logic                   remove_req = 1'b0;
  logic [WB-1:0]          looked_at_cube = '0;
  logic [2:0][NW-1:0]     looked_at_normal = '0;
  logic [WB-1:0]          mem_addr;
  logic [EW-1:0]          mem_wdata;
  logic                   mem_we;
  logic [EW-1:0]          mem_rdata;
  logic                   busy;
  logic                   done;
  logic [1:0]             status;
  logic [WB-1:0]          edited_slot;
  logic [2:0]             fsm_state;

  world_editor #(
    .COORD_WIDTH(CW), .WORLD_SIZE(WS), .WORLD_BITS(WB),
    .NORMAL_WIDTH(NW), .READ_LATENCY(L)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .place_req(place_req), .remove_req(remove_req),
    .looked_at_cube(looked_at_cube), .looked_at_normal(looked_at_normal),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .status(status),
    .edited_slot(edited_slot), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- world RAM model ----------------
  logic [EW-1:0] mem [WS];
  logic [EW-1:0] rd_pipe [L];

  always @(posedge clk_in) begin
    rd_pipe[0] <= (mem_addr < WB'(WS)) ? mem[mem_addr] : '0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]    dcyc;
    logic [1:0]    st;
    logic [WB-1:0] ed;
    logic          we;
    logic [7:0]    wcyc;
    logic [WB-1:0] waddr;
    logic [EW-1:0] wdata;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            scene;
    bit            place;
    bit            remove;
    logic [WB-1:0] cube;
    logic [5:0]    nrm;
    bit            poke;
    int            dcyc;
    logic [1:0]    st;
    logic [WB-1:0] ed;
    bit            we;
    int            wcyc;
    logic [WB-1:0] waddr;
    logic [EW-1:0] wdata;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [EW-1:0] ent(input logic v, input logic [15:0] x,
                                        input logic [15:0] y, input logic [15:0] z);
    return {v, x, y, z};
  endfunction

  function automatic vec_t mk(input int scene, input bit pl, input bit rm,
                              input logic [WB-1:0] cube, input logic [5:0] nrm,
                              input bit poke, input int dcyc, input logic [1:0] st,
                              input logic [WB-1:0] ed, input bit we, input int wcyc,
                              input logic [WB-1:0] waddr, input logic [EW-1:0] wdata);
    vec_t v;
    v.scene = scene; v.place = pl; v.remove = rm; v.cube = cube; v.nrm = nrm;
    v.poke = poke; v.dcyc = dcyc; v.st = st; v.ed = ed; v.we = we;
    v.wcyc = wcyc; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  // Scenes: 0 base, 1 base+occupier at 60, 2 full, 3 low slots filled,
  // 4 base+occupier at last slot, 5 full except last slot.
  task automatic load_scene(input int id);
    for (int i = 0; i < WS; i++) mem[i] = '0;
    if (id == 2 || id == 5)
      for (int i = 0; i < WS; i++) mem[i] = ent(1'b1, 16'(100 + i), 16'd200, 16'd300);
    if (id == 5) mem[99] = '0;
    if (id == 0 || id == 1 || id == 3 || id == 4) begin
      mem[0]  = ent(1'b1, 16'd1, 16'd1, 16'd1);
      mem[1]  = ent(1'b1, 16'd2, 16'd2, 16'd2);
      mem[2]  = ent(1'b1, 16'd3, 16'd3, 16'd3);
      mem[3]  = ent(1'b1, 16'd10, 16'd4, 16'd7);
      mem[5]  = ent(1'b1, 16'd20, 16'd20, 16'd20);
      mem[10] = ent(1'b1, 16'd0, 16'd9, 16'd9);
    end
    if (id == 1) mem[60] = ent(1'b1, 16'd10, 16'd5, 16'd7);
    if (id == 3)
      for (int i = 4; i <= 40; i++) mem[i] = ent(1'b1, 16'(500 + i), 16'd0, 16'd0);
    if (id == 4) mem[99] = ent(1'b1, 16'd11, 16'd3, 16'd7);
  endtask

  // ---------------- driver + monitor ----------------
  task automatic run_vec(input vec_t v);
    exp_t e, g;
    int dcyc, wcnt, wcyc;
    logic [WB-1:0] waddr, ed;
    logic [EW-1:0] wdat;
    logic [1:0] st;
    bit got_done, busy_ok, quiet_ok;
    load_scene(v.scene);
    e.dcyc = v.dcyc[7:0]; e.st = v.st; e.ed = v.ed; e.we = v.we;
    e.wcyc = v.wcyc[7:0]; e.waddr = v.waddr; e.wdata = v.wdata;
    @(negedge clk_in);
    place_req = v.place; remove_req = v.remove;
    looked_at_cube = v.cube; looked_at_normal = v.nrm;
    exp_q.push_back(e);
    got_done = 0; busy_ok = 1; quiet_ok = 1;
    dcyc = 0; wcnt = 0; wcyc = 0; waddr = '0; wdat = '0; st = '0; ed = '0;
    for (int cyc = 1; cyc <= TIMEOUT && !got_done; cyc++) begin
      @(negedge clk_in);
      if (cyc == 1) begin place_req = 0; remove_req = 0; end
      if (v.poke && cyc == 20) place_req = 1;
      if (v.poke && cyc == 30) place_req = 0;
      if (mem_we) begin
        wcnt++; wcyc = cyc; waddr = mem_addr; wdat = mem_wdata;
        if (mem_addr < WB'(WS)) mem[mem_addr] = mem_wdata;
      end
      if (done) begin
        got_done = 1; dcyc = cyc; st = status; ed = edited_slot;
        if (busy) busy_ok = 0;
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      if (done || mem_we) quiet_ok = 0;
    end
    g = exp_t'(exp_q.pop_front());
    check("done_cycle", 64'(dcyc), 64'(g.dcyc));
    check("status", 64'(st), 64'(g.st));
    check("edited_slot", 64'(ed), 64'(g.ed));
    check("busy_window", 64'(busy_ok), 64'd1);
    check("quiet_after_done", 64'(quiet_ok), 64'd1);
    check("write_count", 64'(wcnt), 64'(g.we));
    if (g.we) begin
      check("write_cycle", 64'(wcyc), 64'(g.wcyc));
      check("write_addr", 64'(waddr), 64'(g.waddr));
      check("write_data", 64'(wdat), 64'(g.wdata));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = mk(0, 0, 1, 7'd5,   6'b00_00_00, 0, D_RM,   2'd0, 7'd5,  1, 1,      7'd5,  '0);
    vecs[1]  = mk(0, 1, 0, 7'd3,   6'b00_01_00, 0, D_OK,   2'd0, 7'd4,  1, D_SCAN, 7'd4,  ent(1'b1, 16'd10, 16'd5, 16'd7));
    vecs[2]  = mk(1, 1, 0, 7'd3,   6'b00_01_00, 0, D_SCAN, 2'd2, 7'd4,  0, 0,      7'd0,  '0);
    vecs[3]  = mk(2, 1, 0, 7'd3,   6'b00_00_01, 0, D_SCAN, 2'd3, 7'd4,  0, 0,      7'd0,  '0);
    vecs[4]  = mk(0, 1, 0, 7'd127, 6'b00_01_00, 0, D_IDX,  2'd1, 7'd4,  0, 0,      7'd0,  '0);
    vecs[5]  = mk(0, 0, 1, 7'd100, 6'b00_00_00, 0, D_IDX,  2'd1, 7'd4,  0, 0,      7'd0,  '0);
    vecs[6]  = mk(0, 1, 0, 7'd4,   6'b00_01_00, 0, D_INV,  2'd1, 7'd4,  0, 0,      7'd0,  '0);
    vecs[7]  = mk(0, 1, 1, 7'd5,   6'b00_01_00, 0, D_RM,   2'd0, 7'd5,  1, 1,      7'd5,  '0);
    vecs[8]  = mk(0, 1, 0, 7'd10,  6'b11_00_00, 0, D_OK,   2'd0, 7'd4,  1, D_SCAN, 7'd4,  ent(1'b1, 16'hFFFF, 16'd9, 16'd9));
    vecs[9]  = mk(0, 1, 0, 7'd3,   6'b10_01_11, 0, D_OK,   2'd0, 7'd4,  1, D_SCAN, 7'd4,  ent(1'b1, 16'd10, 16'd5, 16'd6));
    vecs[10] = mk(3, 1, 0, 7'd3,   6'b01_11_00, 0, D_OK,   2'd0, 7'd41, 1, D_SCAN, 7'd41, ent(1'b1, 16'd11, 16'd3, 16'd7));
    vecs[11] = mk(4, 1, 0, 7'd3,   6'b01_11_00, 0, D_SCAN, 2'd2, 7'd41, 0, 0,      7'd0,  '0);
    vecs[12] = mk(5, 1, 0, 7'd3,   6'b00_00_01, 0, D_OK,   2'd0, 7'd99, 1, D_SCAN, 7'd99, ent(1'b1, 16'd103, 16'd200, 16'd301));
    vecs[13] = mk(0, 1, 0, 7'd3,   6'b00_01_00, 1, D_OK,   2'd0, 7'd4,  1, D_SCAN, 7'd4,  ent(1'b1, 16'd10, 16'd5, 16'd7));

    load_scene(0);
    #12;
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_edited_slot", 64'(edited_slot), 64'd0);
    check("rst_fsm_state", 64'(fsm_state), 64'd0);
    @(negedge clk_in);
    rst_in = 0;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset in the middle of a scan, then a normal request.
    load_scene(0);
    @(negedge clk_in);
    place_req = 1; looked_at_cube = 7'd3; looked_at_normal = 6'b00_01_00;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk_in);
      if (cyc == 1) place_req = 0;
    end
    check("scan_busy_before_rst", 64'(busy), 64'd1);
    rst_in = 1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_fsm_state", 64'(fsm_state), 64'd0);
    @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    run_vec(mk(0, 0, 1, 7'd5, 6'b00_00_00, 0, D_RM, 2'd0, 7'd5, 1, 1, 7'd5, '0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
